// File: rtl/r5p_gpr_pkg.sv
// Shared types and constants for the R5P general purpose register file.
package r5p_gpr_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } gpr_clr_t;

  // address bits inside one 16-deep distributed-RAM bank
  localparam int unsigned BANK_AW = 4;

endpackage

// File: rtl/r5p_gpr_bank.sv
// One storage copy of the register file: 2**(AW-4) banks of 16 x XLEN,
// one write port and one asynchronous read port.
module r5p_gpr_bank
  import r5p_gpr_pkg::*;
#(
  parameter int unsigned AW   = 5,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   a_w,
  input  logic [XLEN-1:0] d_w,
  input  logic [AW-1:0]   a_r,
  output logic [XLEN-1:0] d_r
);

  localparam int unsigned NB = 2**(AW-BANK_AW);
  localparam int unsigned BW = (AW > BANK_AW) ? AW-BANK_AW : 1;

  logic [BW-1:0]   bs_w;
  logic [BW-1:0]   bs_r;
  logic [XLEN-1:0] rd_bank [NB];

  assign bs_w = BW'(a_w >> BANK_AW);
  assign bs_r = BW'(a_r >> BANK_AW);

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [XLEN-1:0] mem [2**BANK_AW];
    logic            bwe;

    assign bwe = we & (bs_w == BW'(b));

    always_ff @(posedge clk) begin
      if (bwe) mem[a_w[BANK_AW-1:0]] <= d_w;
    end

    assign rd_bank[b] = mem[a_r[BANK_AW-1:0]];
  end

  assign d_r = rd_bank[bs_r];

endmodule

// File: rtl/r5p_gpr_nr1w_clr.sv
// NR-read / 1-write GPR file with post-reset clear sweep, optional write
// bypass and optional registered read ports. One storage copy per read port.
module r5p_gpr_nr1w_clr
  import r5p_gpr_pkg::*;
#(
  parameter int unsigned NR   = 2,
  parameter int unsigned AW   = 5,
  parameter int unsigned XLEN = 32,
  parameter bit          WBYP = 1'b0,
  parameter bit          RREG = 1'b0,
  parameter bit          CLR  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en0,
  output logic                     rdy,
  input  logic [NR-1:0]            e_rs,
  input  logic [NR-1:0][AW-1:0]    a_rs,
  output logic [NR-1:0][XLEN-1:0]  d_rs,
  input  logic                     e_rd,
  input  logic [AW-1:0]            a_rd,
  input  logic [XLEN-1:0]          d_rd
);

  localparam gpr_clr_t RST_STATE = CLR ? CLEAR : RUN;

  gpr_clr_t        state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            wen;
  logic            b_we;
  logic [AW-1:0]   b_a;
  logic [XLEN-1:0] b_d;
  logic [XLEN-1:0] mem_rd [NR];
  logic [XLEN-1:0] rd_val [NR];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = RUN;
    end
  end

  assign rdy = (state_q == RUN);
  assign wen = rdy & e_rd & (|a_rd | en0);

  // the clear sweep owns the write port until the file is ready
  assign b_we = ~rdy | wen;
  assign b_a  = rdy ? a_rd : cnt_q;
  assign b_d  = rdy ? d_rd : '0;

  for (genvar i = 0; i < NR; i++) begin : g_copy
    r5p_gpr_bank #(
      .AW   (AW),
      .XLEN (XLEN)
    ) u_bank (
      .clk (clk),
      .we  (b_we),
      .a_w (b_a),
      .d_w (b_d),
      .a_r (a_rs[i]),
      .d_r (mem_rd[i])
    );
  end

  // x0 masking overrides the bypass
  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      rd_val[i] = mem_rd[i];
      if (WBYP && wen && (a_rd == a_rs[i])) rd_val[i] = d_rd;
      if (!en0 && (a_rs[i] == '0))          rd_val[i] = '0;
    end
  end

  if (RREG) begin : g_rreg
    logic [NR-1:0][XLEN-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q <= '0;
      end else begin
        for (int unsigned i = 0; i < NR; i++) begin
          if (e_rs[i] & rdy) q[i] <= rd_val[i];
        end
      end
    end

    // registers are reset and never loaded during the sweep, so they read 0 there
    assign d_rs = q;
  end else begin : g_async
    logic unused_e_rs;

    assign unused_e_rs = ^e_rs;

    always_comb begin
      for (int unsigned i = 0; i < NR; i++) begin
        d_rs[i] = rdy ? rd_val[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_r5p_gpr_nr1w_clr.sv
// Randomised self-checking bench: three configurations of the register file
// share stimulus and are compared against an array-based reference model.
module tb_r5p_gpr_nr1w_clr;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int XL = 32;
  localparam int DEPTH = 2**AW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en0;
  logic [NR-1:0]        e_rs;
  logic [NR-1:0][AW-1:0] a_rs;
  logic                 e_rd;
  logic [AW-1:0]        a_rd;
  logic [XL-1:0]        d_rd;
  logic                 rdy0, rdy1, rdy2;
  logic [NR-1:0][XL-1:0] d0, d1, d2;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model
  logic [XL-1:0] m_mem [DEPTH];
  logic [XL-1:0] m_q   [NR];
  bit            m_rdy;
  int            m_edges;

  always #5 clk = ~clk;

  // async read, write bypass
  r5p_gpr_nr1w_clr #(.NR(NR), .AW(AW), .XLEN(XL), .WBYP(1'b1), .RREG(1'b0), .CLR(1'b1)) dut0 (
    .clk(clk), .rst(rst), .en0(en0), .rdy(rdy0), .e_rs(e_rs), .a_rs(a_rs), .d_rs(d0),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd));
  // registered read, no bypass
  r5p_gpr_nr1w_clr #(.NR(NR), .AW(AW), .XLEN(XL), .WBYP(1'b0), .RREG(1'b1), .CLR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en0(en0), .rdy(rdy1), .e_rs(e_rs), .a_rs(a_rs), .d_rs(d1),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd));
  // async read, no bypass
  r5p_gpr_nr1w_clr #(.NR(NR), .AW(AW), .XLEN(XL), .WBYP(1'b0), .RREG(1'b0), .CLR(1'b1)) dut2 (
    .clk(clk), .rst(rst), .en0(en0), .rdy(rdy2), .e_rs(e_rs), .a_rs(a_rs), .d_rs(d2),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd));

  task automatic check(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int p = 0; p < NR; p++) m_q[p] = '0;
    m_rdy   = 1'b0;
    m_edges = 0;
  endtask

  function automatic bit m_wen();
    return m_rdy && e_rd && (a_rd != '0 || en0);
  endfunction

  function automatic logic [XL-1:0] exp_rd(int p, bit byp);
    if (!m_rdy) return '0;
    if (!en0 && a_rs[p] == '0) return '0;
    if (byp && m_wen() && a_rd == a_rs[p]) return d_rd;
    return m_mem[a_rs[p]];
  endfunction

  task automatic m_edge();
    if (!rst) begin
      m_reset();
    end else if (!m_rdy) begin
      m_edges++;
      if (m_edges == DEPTH) m_rdy = 1'b1;
    end else begin
      for (int p = 0; p < NR; p++)
        if (e_rs[p]) m_q[p] = exp_rd(p, 1'b0);
      if (m_wen()) m_mem[a_rd] = d_rd;
    end
  endtask

  // inputs are set just after a posedge; async outputs are checked at the
  // following negedge, registered outputs just after the next posedge
  task automatic step();
    @(negedge clk);
    check("rdy0", {31'd0, rdy0}, {31'd0, m_rdy});
    check("rdy2", {31'd0, rdy2}, {31'd0, m_rdy});
    for (int p = 0; p < NR; p++) begin
      check($sformatf("byp_async_p%0d_a%0d", p, a_rs[p]), d0[p], exp_rd(p, 1'b1));
      check($sformatf("nobyp_async_p%0d_a%0d", p, a_rs[p]), d2[p], exp_rd(p, 1'b0));
    end
    @(posedge clk);
    m_edge();
    #1;
    check("rdy1", {31'd0, rdy1}, {31'd0, m_rdy});
    for (int p = 0; p < NR; p++)
      check($sformatf("reg_p%0d", p), d1[p], m_q[p]);
  endtask

  task automatic drive(input logic i_en0, input logic i_e_rd, input logic [AW-1:0] i_a_rd,
                       input logic [XL-1:0] i_d_rd, input logic [NR-1:0] i_e_rs,
                       input logic [AW-1:0] i_a0, input logic [AW-1:0] i_a1);
    en0 = i_en0; e_rd = i_e_rd; a_rd = i_a_rd; d_rd = i_d_rd;
    e_rs = i_e_rs; a_rs[0] = i_a0; a_rs[1] = i_a1;
    step();
  endtask

  task automatic rand_step();
    en0  = ($urandom_range(0, 3) != 0);
    e_rd = 1'($urandom_range(0, 1));
    a_rd = AW'($urandom_range(0, DEPTH-1));
    d_rd = $urandom;
    e_rs = NR'($urandom_range(0, 3));
    for (int p = 0; p < NR; p++)
      a_rs[p] = ($urandom_range(0, 2) == 0) ? a_rd : AW'($urandom_range(0, DEPTH-1));
    step();
  endtask

  initial begin
    rst = 1'b1; en0 = 1'b0; e_rd = 1'b0; a_rd = '0; d_rd = '0; e_rs = '0; a_rs = '0;
    #2 rst = 1'b0;
    m_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // sweep: random traffic must be ignored, rdy rises on edge 32
    for (int k = 0; k < DEPTH; k++) rand_step();
    check("rdy_after_sweep", {31'd0, rdy0}, 32'd1);

    // every address reads zero on every port
    for (int k = 0; k < DEPTH; k++)
      drive(1'b1, 1'b0, '0, '0, 2'b11, AW'(k), AW'(DEPTH-1-k));

    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd1, 5'd2);
    drive(1'b1, 1'b0, '0, '0, 2'b11, 5'd5, 5'd5);

    drive(1'b0, 1'b1, 5'd0, 32'h1234, 2'b00, 5'd1, 5'd2);
    drive(1'b0, 1'b0, '0, '0, 2'b11, 5'd0, 5'd0);
    drive(1'b1, 1'b0, '0, '0, 2'b11, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd0, 32'h1234, 2'b00, 5'd1, 5'd2);
    drive(1'b1, 1'b0, '0, '0, 2'b11, 5'd0, 5'd0);

    // same-cycle write/read of x7: bypassed vs old value
    drive(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 2'b10, 5'd1, 5'd7);
    drive(1'b1, 1'b0, '0, '0, 2'b10, 5'd1, 5'd7);

    // registered port: load x3, then hold while address moves
    drive(1'b1, 1'b1, 5'd3, 32'h0BADF00D, 2'b00, 5'd0, 5'd0);
    drive(1'b1, 1'b0, '0, '0, 2'b01, 5'd3, 5'd0);
    drive(1'b1, 1'b0, '0, '0, 2'b00, 5'd5, 5'd0);
    check("rreg_hold", d1[0], 32'h0BADF00D);

    for (int k = 0; k < 400; k++) rand_step();

    // reset mid-traffic
    drive(1'b1, 1'b1, 5'd9, 32'h55, 2'b00, 5'd0, 5'd0);
    rst = 1'b0;
    m_reset();
    for (int k = 0; k < 3; k++) rand_step();
    rst = 1'b1;
    for (int k = 0; k < DEPTH - 1; k++) rand_step();
    check("rdy_low_edge31", {31'd0, rdy0}, 32'd0);
    rand_step();
    check("rdy_high_edge32", {31'd0, rdy0}, 32'd1);
    drive(1'b1, 1'b0, '0, '0, 2'b11, 5'd9, 5'd9);
    check("x9_cleared", d2[0], 32'd0);
    drive(1'b1, 1'b0, '0, '0, 2'b00, 5'd9, 5'd9);
    check("x9_cleared_reg", d1[1], 32'd0);

    for (int k = 0; k < 200; k++) rand_step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
